led_panel_tx: RTL and testbench

Serial transmitter that drives a daisy-chain of shift-register LED driver devices on the panel model. It accepts one parallel word per device through a valid/ready handshake and shifts it out MSB-first on sdi/sclk. After each word it pulses le, so the panel-side device counter advances once per word. It sits between the frame source and the driver chain, and keeps dev_idx in lock-step with the panel-side device counter.

---
 rtl/led_panel_tx.sv | 129 ++++++++++++
 tb/tb_led_panel_tx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/led_panel_tx.sv
// led_panel_tx: serial word transmitter for a daisy-chain of shift-register LED drivers
// Ports: clk, rst_n (sync, active low); start (frame request, IDLE only);
//   data_in/data_valid/data_ready (one word per device handshake);
//   sdi/sclk (MSB-first serial data, sampled on sclk rise); le (latch pulse per word);
//   oe_n (driver enable, active low); dev_idx (device being loaded); busy; done (frame end pulse).
// Optional macro LED_PANEL_TX_BLANK_EN: blank oe_n while data moves through the chain.
module led_panel_tx #(
  parameter int NUMBER_OF_DEVICES = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic data_valid,
  output logic data_ready,
  output logic sdi,
  output logic sclk,
  output logic le,
  output logic oe_n,
  output logic [4:0] dev_idx,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [4:0] DEV_LAST = 5'(NUMBER_OF_DEVICES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, NEXT} state_t;
  state_t state_q;
  // MSB goes straight to sdi on transfer, so only the remaining bits are held
  logic [DATA_WIDTH-2:0] sr_q;
  logic [BW-1:0] bit_q;
  logic [CW-1:0] div_q;
  logic sdi_q, sclk_q, le_q, oe_n_q, done_q;
  logic [4:0] dev_idx_q;
  logic last;
`ifdef LED_PANEL_TX_BLANK_EN
  logic frame_done_q;
`endif
  assign last = dev_idx_q == DEV_LAST;
  assign data_ready = state_q == LOAD;
  assign busy = state_q != IDLE;
  assign sdi = sdi_q;
  assign sclk = sclk_q;
  assign le = le_q;
  assign oe_n = oe_n_q;
  assign dev_idx = dev_idx_q;
  assign done = done_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      bit_q <= '0;
      div_q <= '0;
      sdi_q <= 1'b0;
      sclk_q <= 1'b0;
      le_q <= 1'b0;
      oe_n_q <= 1'b1;
      done_q <= 1'b0;
      dev_idx_q <= '0;
`ifdef LED_PANEL_TX_BLANK_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          dev_idx_q <= '0;
        end
        LOAD: if (data_valid) begin
          sr_q <= data_in[DATA_WIDTH-2:0];
          sdi_q <= data_in[DATA_WIDTH-1];
          bit_q <= BIT_LAST;
          div_q <= '0;
          state_q <= SHIFT;
`ifdef LED_PANEL_TX_BLANK_EN
          oe_n_q <= 1'b1;
`endif
        end
        // sclk flips at the end of each half; sdi advances only on the falling flip
        SHIFT: if (div_q == HALF_LAST) begin
          div_q <= '0;
          sclk_q <= ~sclk_q;
          if (sclk_q) begin
            if (bit_q == '0) begin
              sdi_q <= 1'b0;
              le_q <= 1'b1;
              state_q <= LATCH;
            end else begin
              sdi_q <= sr_q[DATA_WIDTH-2];
              sr_q <= sr_q << 1;
              bit_q <= bit_q - 1'b1;
            end
          end
        end else begin
          div_q <= div_q + 1'b1;
        end
        // done is raised here so it is visible during NEXT, with le already low
        LATCH: if (div_q == LATCH_LAST) begin
          div_q <= '0;
          le_q <= 1'b0;
          state_q <= NEXT;
          if (last) begin
            done_q <= 1'b1;
`ifndef LED_PANEL_TX_BLANK_EN
            oe_n_q <= 1'b0;
`endif
          end
        end else begin
          div_q <= div_q + 1'b1;
        end
        NEXT: begin
          dev_idx_q <= last ? 5'd0 : dev_idx_q + 5'd1;
          state_q <= last ? IDLE : LOAD;
`ifdef LED_PANEL_TX_BLANK_EN
          if (last) frame_done_q <= 1'b1;
          oe_n_q <= ~(last || frame_done_q);
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_panel_tx.sv
// tb_led_panel_tx: directed bench for led_panel_tx (default and minimal configurations)
module tb_led_panel_tx;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, data_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic data_ready, sdi, sclk, le, oe_n, busy, done;
  logic [4:0] dev_idx;
  logic start_s = 1'b0, dv_s = 1'b0;
  logic [1:0] din_s = '0;
  logic ready_s, sdi_s, sclk_s, le_s, oe_n_s, busy_s, done_s;
  logic [4:0] dev_idx_s;
  int tests = 0, fails = 0;
`ifdef LED_PANEL_TX_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  always #5 clk = ~clk;
  led_panel_tx u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .sdi(sdi), .sclk(sclk), .le(le), .oe_n(oe_n),
    .dev_idx(dev_idx), .busy(busy), .done(done)
  );
  led_panel_tx #(.NUMBER_OF_DEVICES(1), .DATA_WIDTH(2), .CLK_DIV(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .data_in(din_s), .data_valid(dv_s),
    .data_ready(ready_s), .sdi(sdi_s), .sclk(sclk_s), .le(le_s), .oe_n(oe_n_s),
    .dev_idx(dev_idx_s), .busy(busy_s), .done(done_s)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] word_of(input logic [63:0] w, input int k);
    return w[(3 - k) * 16 +: 16];
  endfunction
  task automatic check_reset;
    check("rst_out", {sdi, sclk, le, oe_n, busy, done, data_ready}, 7'b0001000);
    check("rst_dev", dev_idx, 0);
    check("rst_out_s", {sdi_s, sclk_s, le_s, oe_n_s, busy_s, done_s, ready_s}, 7'b0001000);
  endtask
  // Cycle n counts clock edges after the edge that samples start.
  task automatic run_frame(input logic [63:0] w, input int bp_dev, input bit first);
    int n, k, bp, le_len, bits, busy_falls, done_cnt, tail, le_fall, done_n, dly;
    logic [15:0] cap;
    logic psclk, ple, pbusy;
    logic [4:0] pdev;
    n = 1; k = 0; bp = 0; le_len = 0; bits = 0; busy_falls = 0; done_cnt = 0;
    tail = 0; le_fall = 0; done_n = 0; cap = '0; psclk = 0; ple = 0; pbusy = 1; pdev = '0;
    data_valid = 1'b1;
    data_in = word_of(w, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    while (n < 400 && tail < 5) begin
      dly = (bp_dev >= 0 && k >= bp_dev) ? 10 : 0;
      if (sclk && !psclk) begin
        cap = {cap[14:0], sdi};
        bits++;
      end
      if (le && !ple) begin
        check("le_start", n, 66 + 70 * k + dly);
        check("word", cap, word_of(w, k));
        check("bits", bits, 16);
        check("oe_n_xfer", oe_n, (BLANK || first) ? 1 : 0);
        cap = '0;
        bits = 0;
        le_len = 0;
      end
      if (le) le_len++;
      if (!le && ple) begin
        check("le_len", le_len, 4);
        le_fall = n;
        k++;
      end
      if (dev_idx != pdev) begin
        check("dev_idx", dev_idx, k % 4);
        check("dev_idx_t", n, le_fall + 1);
      end
      if (done) begin
        done_cnt++;
        done_n = n;
        check("done_t", n, 280 + ((bp_dev >= 0) ? 10 : 0));
        check("oe_n_done", oe_n, BLANK ? 1 : 0);
      end
      if (done_n > 0 && n == done_n + 1) check("oe_n_after", oe_n, 0);
      if (pbusy && !busy) busy_falls++;
      if (done_n > 0) tail++;
      start = (n == 20) || done;
      if (int'(dev_idx) == bp_dev && (data_ready || bp > 0) && bp < 10) begin
        if (bp > 0) check("bp_hold", {data_ready, sclk, le}, 3'b100);
        data_valid = 1'b0;
        bp++;
      end else begin
        data_valid = 1'b1;
      end
      data_in = word_of(w, int'(dev_idx) % 4);
      psclk = sclk; ple = le; pbusy = busy; pdev = dev_idx;
      tick;
      n++;
    end
    start = 1'b0;
    check("frame_done_cnt", done_cnt, 1);
    check("busy_falls", busy_falls, 1);
    check("le_count", k, 4);
    check("idle", {busy, dev_idx, oe_n}, 7'b0);
  endtask
  task automatic run_small(input bit first);
    logic [4:0] tbl [9];
    logic eo;
    tbl = '{5'b00001, 5'b01001, 5'b11001, 5'b00001, 5'b10001,
            5'b00101, 5'b00101, 5'b00011, 5'b00000};
    din_s = 2'b10;
    dv_s = 1'b1;
    start_s = 1'b1;
    tick;
    start_s = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      eo = BLANK ? ((first && n <= 8) || (n >= 2 && n <= 8)) : (first && n <= 7);
      check("small", {sclk_s, sdi_s, le_s, done_s, busy_s, oe_n_s}, {tbl[n-1], eo});
      tick;
    end
    check("small_dev", dev_idx_s, 0);
    dv_s = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    tick;
    tick;
    check_reset;
    rst_n = 1'b1;
    tick;
    data_in = 16'hFFFF;
    data_valid = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (30) tick;
    check("busy_pre_rst", {busy, sdi}, 2'b11);
    rst_n = 1'b0;
    tick;
    check_reset;
    rst_n = 1'b1;
    tick;
    run_frame({16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF}, -1, 1'b1);
    run_frame({16'h0001, 16'h8000, 16'hFFFF, 16'h0000}, -1, 1'b0);
    run_frame({16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 2, 1'b0);
    run_small(1'b1);
    run_small(1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
